// File: rtl/arb_pkg.sv
// Shared arbiter definitions: the FSM state encoding used by rr_arb_lock.
package arb_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_e;

endpackage : arb_pkg

// File: rtl/rr_arb_lock_bitscan.sv
// Lowest-set-bit finder: one-hot of the lowest set bit, its binary index and a found flag.
module rr_arb_lock_bitscan #(
  parameter  int unsigned W  = 16,
  localparam int unsigned IW = $clog2(W)
) (
  input  logic [W-1:0]  vec_i,
  output logic [W-1:0]  onehot_o,
  output logic [IW-1:0] idx_o,
  output logic          found_o
);

  always_comb begin
    onehot_o = '0;
    idx_o    = '0;
    found_o  = 1'b0;
    for (int unsigned i = 0; i < W; i++) begin
      if (vec_i[i] && !found_o) begin
        found_o     = 1'b1;
        onehot_o[i] = 1'b1;
        idx_o       = IW'(i);
      end
    end
  end

endmodule : rr_arb_lock_bitscan

// File: rtl/rr_arb_lock.sv
// Round-robin arbiter whose grant is held until the owner releases it.
// Optional forced release after TIMEOUT cycles: define RR_ARB_LOCK_TIMEOUT_EN.
module rr_arb_lock
  import arb_pkg::*;
#(
  parameter  int unsigned WIDTH   = 16,
  parameter  int unsigned TIMEOUT = 255,
  localparam int unsigned IW      = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] req,
  input  logic             release_i,
  output logic [WIDTH-1:0] grant,
  output logic [IW-1:0]    grant_idx,
  output logic             grant_valid,
  output logic             timeout_o
);

  if (WIDTH < 2 || TIMEOUT < 1) begin : g_param_check
    $error("rr_arb_lock: WIDTH must be >= 2 and TIMEOUT >= 1");
  end

  arb_state_e       state_q;
  logic [WIDTH-1:0] grant_q;
  logic [IW-1:0]    idx_q;
  logic             valid_q;
  logic [WIDTH-1:0] mask_q;
  logic [WIDTH-1:0] mask_d;

  logic [WIDTH-1:0] m_oh, u_oh, win_oh;
  logic [IW-1:0]    m_idx, u_idx, win_idx;
  logic             m_found, any_req;
  logic             timeout_hit;

  rr_arb_lock_bitscan #(.W(WIDTH)) u_scan_masked (
    .vec_i    (req & mask_q),
    .onehot_o (m_oh),
    .idx_o    (m_idx),
    .found_o  (m_found)
  );

  rr_arb_lock_bitscan #(.W(WIDTH)) u_scan_all (
    .vec_i    (req),
    .onehot_o (u_oh),
    .idx_o    (u_idx),
    .found_o  (any_req)
  );

  assign win_oh  = m_found ? m_oh  : u_oh;
  assign win_idx = m_found ? m_idx : u_idx;

  // Post-release mask: only requesters strictly above the current owner.
  always_comb begin
    mask_d = '0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      mask_d[i] = (IW'(i) > idx_q);
    end
  end

`ifdef RR_ARB_LOCK_TIMEOUT_EN
  localparam int unsigned CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0] cnt_q;

  // Combinational so a coincident release_i suppresses the pulse.
  assign timeout_hit = (state_q == GRANT) && (cnt_q == CW'(TIMEOUT - 1)) && !release_i;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (state_q != GRANT) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + 1'b1;
    end
  end
`else
  assign timeout_hit = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      grant_q <= '0;
      idx_q   <= '0;
      valid_q <= 1'b0;
      mask_q  <= '1;
    end else begin
      case (state_q)
        IDLE: begin
          if (any_req) begin
            grant_q <= win_oh;
            idx_q   <= win_idx;
            valid_q <= 1'b1;
            state_q <= GRANT;
          end
        end
        GRANT: begin
          if (release_i || timeout_hit) begin
            grant_q <= '0;
            idx_q   <= '0;
            valid_q <= 1'b0;
            mask_q  <= mask_d;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign grant       = grant_q;
  assign grant_idx   = idx_q;
  assign grant_valid = valid_q;
  assign timeout_o   = timeout_hit;

endmodule : rr_arb_lock

// File: doc/rr_arb_lock.md
RR_ARB_LOCK -- requirements
Module: rr_arb_lock

Interface
REQ-001 SHALL have parameter WIDTH, default 16, number of requesters (>=2).
REQ-002 SHALL have parameter TIMEOUT, default 255, maximum grant hold cycles; only used with RR_ARB_LOCK_TIMEOUT_EN.
REQ-003 SHALL have port clk  input  1  single clock, all logic rising-edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port req  input  WIDTH  request vector, bit i = requester i.
REQ-006 SHALL have port release_i  input  1  current owner done; single-cycle pulse.
REQ-007 SHALL have port grant  output  WIDTH  registered one-hot grant, or zero.
REQ-008 SHALL have port grant_idx  output  $clog2(WIDTH)  binary index of the set grant bit.
REQ-009 SHALL have port grant_valid  output  1  high exactly when grant is non-zero.
REQ-010 SHALL have port timeout_o  output  1  one-cycle pulse on forced release.

Function
REQ-011 SHALL implement a two-state FSM: IDLE, GRANT.
REQ-012 SHALL, in IDLE with |req, pick winner = lowest set bit of (req & mask) if non-zero, else lowest set bit of req.
REQ-013 SHALL register the winner into grant/grant_idx, assert grant_valid and enter GRANT at the next edge, giving 1-cycle latency from req to grant.
REQ-014 SHALL stay in IDLE with grant=0 when req=0.
REQ-015 SHALL hold grant unchanged in GRANT regardless of req changes, including the owner deasserting its request.
REQ-016 SHALL, on release_i in GRANT, clear grant/grant_valid at the next edge and return to IDLE.
REQ-017 SHALL arbitrate no earlier than the cycle after returning to IDLE, giving one bubble cycle between grants.
REQ-018 SHALL, on release, set mask = bits strictly above the released index; a release of index WIDTH-1 yields mask=0, which gives wrap-around to the lowest requester.
REQ-019 SHALL ignore release_i in IDLE.
REQ-020 SHALL never output more than one grant bit set.

Reset
REQ-021 SHALL, on rst, immediately set grant=0, grant_idx=0, grant_valid=0, timeout_o=0, state=IDLE, mask=all ones, hold counter=0, including mid-grant.

Configuration
REQ-022 SHALL, with macro RR_ARB_LOCK_TIMEOUT_EN defined, count cycles in GRANT (reset to 0 on entry), force a release when the count reaches TIMEOUT-1 without release_i, pulse timeout_o for that cycle, and update mask as for a normal release.
REQ-023 SHALL, without RR_ARB_LOCK_TIMEOUT_EN, contain no counter, hold grant indefinitely until release_i, and tie timeout_o to 0.
REQ-024 SHALL treat coincident release_i and timeout as a normal release, with timeout_o=0.

Structure
REQ-025 SHALL place the FSM state enum (IDLE, GRANT) in shared package arb_pkg.
REQ-026 SHALL instantiate the existing bitscan lowest-set-bit sub-module twice (masked and unmasked) for winner selection; no other sub-modules.

Verification (WIDTH=4, TIMEOUT=8)
REQ-027 SHALL check: after rst, req=4'b1010 -> next cycle grant=4'b0010, grant_idx=1, grant_valid=1.
REQ-028 SHALL check: while holding 4'b0010, req changes to 4'b0001 with no release -> grant stays 4'b0010 for 20 cycles.
REQ-029 SHALL check: req=4'b1011, release of idx 1 -> one idle cycle, then grant=4'b1000; release again -> grant=4'b0001 (wrap).
REQ-030 SHALL check: release_i pulsed in IDLE with req=0 -> grant stays 0 and mask stays all ones (next req=4'b1111 -> 4'b0001).
REQ-031 SHALL check: rst asserted mid-grant -> grant=0 without waiting for a clock edge; after rst, req=4'b1111 -> grant=4'b0001.
REQ-032 SHALL check with RR_ARB_LOCK_TIMEOUT_EN: grant with no release -> timeout_o pulses on the 8th GRANT cycle, grant clears next edge, next winner is above the timed-out index.
